// File: rtl/gen_pattern_pkg.sv
// Shared definitions for the pattern data generator: mode codes, FSM states
// and the checkerboard constant helper.
package gen_pattern_pkg;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP
  } state_e;

  // Bit idx of the even-row checkerboard constant (0b...1010): odd bit positions are set.
  function automatic logic checker_bit(input int idx);
    return (idx % 2) == 1;
  endfunction

endpackage

// File: rtl/gen_pattern_word.sv
// Combinational pattern generator: maps (mode, row, constant) to one pattern word.
module gen_pattern_word
  import gen_pattern_pkg::*;
#(
  parameter int WORD_W = 12,
  parameter int ROW_W  = 6
) (
  input  logic [1:0]        mode_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [WORD_W-1:0] const_i,
  output logic [WORD_W-1:0] word_o
);

  genvar gi;

  logic [WORD_W-1:0] ramp_word;
  logic [WORD_W-1:0] check_even;
  logic [31:0]       walk_idx;

  // Ramp is the full-width row index truncated (or zero-extended) to WORD_W.
  generate
    if (ROW_W >= WORD_W) begin : g_ramp_trunc
      assign ramp_word = row_i[WORD_W-1:0];
    end else begin : g_ramp_ext
      assign ramp_word = {{(WORD_W - ROW_W){1'b0}}, row_i};
    end
  endgenerate

  // Even-row checkerboard constant, assembled bit by bit for any width.
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_check
      assign check_even[gi] = checker_bit(gi);
    end
  endgenerate

  assign walk_idx = 32'(row_i) % 32'(WORD_W);

  // Select the pattern for the requested mode.
  always_comb begin
    word_o = ramp_word;
    case (mode_i)
      MODE_RAMP:  word_o = ramp_word;
      MODE_CONST: word_o = const_i;
      MODE_WALK:  word_o = {{(WORD_W - 1){1'b0}}, 1'b1} << walk_idx;
      MODE_CHECK: word_o = row_i[0] ? ~check_even : check_even;
      default:    word_o = ramp_word;
    endcase
  end

endmodule

// File: rtl/gen_pattern_data.sv
// Frame-based test pattern source with valid/ready output, run/stop control
// and an optional idle gap between frames. SR_OUT flags the last row.
module gen_pattern_data
  import gen_pattern_pkg::*;
#(
  parameter int ROWS       = 48,
  parameter int WORD_W     = 12,
  parameter int FRAME_W    = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic [1:0]                MODE,
  input  logic [WORD_W-1:0]         CONST_VAL,
  input  logic                      READY_IN,
  output logic [FRAME_W+WORD_W-1:0] DATA_OUT,
  output logic                      VALID_OUT,
  output logic                      SR_OUT,
  output logic                      BUSY
);

  localparam int               ROW_W    = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HAS_GAP  = GAP_CYCLES > 0;

  state_e                      state_q, state_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [FRAME_W-1:0]          frame_q, frame_d;
  logic [1:0]                  mode_q, mode_d;
  logic [WORD_W-1:0]           const_q, const_d;
  logic [FRAME_W+WORD_W-1:0]   data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        sr_q, sr_d;
  logic [GAP_W-1:0]            gap_q, gap_d;

  logic              beat;
  logic              last_row;
  logic              frame_end;
  logic              gap_done;
  logic              start_frame;
  logic              advance;
  logic [1:0]        gen_mode;
  logic [WORD_W-1:0] gen_const;
  logic [ROW_W-1:0]  gen_row;
  logic [WORD_W-1:0] gen_word;

  // Frame control events. A new frame starts from IDLE, straight after the
  // last beat when there is no gap, or when the gap expires -- only with EN.
  assign beat        = valid_q & READY_IN;
  assign last_row    = (row_q == LAST_ROW);
  assign frame_end   = (state_q == ST_RUN) && beat && last_row;
  assign gap_done    = (state_q == ST_GAP) && (gap_q == GAP_LAST);
  assign start_frame = EN && ((state_q == ST_IDLE) || (frame_end && !HAS_GAP) || gap_done);
  assign advance     = (state_q == ST_RUN) && beat && !last_row;

  // Row 0 of a new frame uses the live MODE/CONST_VAL; later rows use the latched copy.
  assign gen_mode  = start_frame ? MODE : mode_q;
  assign gen_const = start_frame ? CONST_VAL : const_q;
  assign gen_row   = start_frame ? '0 : row_q + 1'b1;

  gen_pattern_word #(
    .WORD_W (WORD_W),
    .ROW_W  (ROW_W)
  ) u_word (
    .mode_i  (gen_mode),
    .row_i   (gen_row),
    .const_i (gen_const),
    .word_o  (gen_word)
  );

  // Next-state logic. Loads happen only on a beat or while VALID_OUT is low,
  // so the output register never changes under a stall.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    frame_d = frame_q;
    mode_d  = mode_q;
    const_d = const_q;
    data_d  = data_q;
    valid_d = valid_q;
    sr_d    = sr_q;
    gap_d   = gap_q;

    if (frame_end) begin
      frame_d = frame_q + 1'b1;
    end

    if (start_frame) begin
      state_d = ST_RUN;
      mode_d  = MODE;
      const_d = CONST_VAL;
    end

    if (start_frame || advance) begin
      row_d   = gen_row;
      data_d  = {frame_d, gen_word};
      valid_d = 1'b1;
      sr_d    = (gen_row == LAST_ROW);
    end else if (frame_end) begin
      valid_d = 1'b0;
      sr_d    = 1'b0;
      gap_d   = '0;
      state_d = HAS_GAP ? ST_GAP : ST_IDLE;
    end else if (state_q == ST_GAP) begin
      if (gap_done) begin
        state_d = ST_IDLE;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // State and output registers with asynchronous abort.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      frame_q <= '0;
      mode_q  <= MODE_RAMP;
      const_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sr_q    <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      const_q <= const_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sr_q    <= sr_d;
      gap_q   <= gap_d;
    end
  end

  assign DATA_OUT  = data_q;
  assign VALID_OUT = valid_q;
  assign SR_OUT    = sr_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gen_pattern_data.sv
// Bench for gen_pattern_data: instance A uses default parameters (no gap),
// instance B uses a 3-cycle inter-frame gap. A frame-level model predicts
// every output; directed literal checks pin the model.
module tb_gen_pattern_data;

  localparam int ROWS = 48;

  typedef struct {
    bit act;
    int row;
    int frame;
    int mode;
    int cval;
    int gap;
  } mst_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance A (GAP_CYCLES = 0)
  logic        RST_N_a = 1'b0, EN_a = 1'b0, READY_a = 1'b1;
  logic [1:0]  MODE_a = 2'd0;
  logic [11:0] CONST_a = 12'h000;
  logic [15:0] DATA_A;
  logic        VALID_A, SR_A, BUSY_A;

  // Instance B (GAP_CYCLES = 3)
  logic        RST_N_b = 1'b0, EN_b = 1'b0, READY_b = 1'b1;
  logic [1:0]  MODE_b = 2'd0;
  logic [11:0] CONST_b = 12'h000;
  logic [15:0] DATA_B;
  logic        VALID_B, SR_B, BUSY_B;

  gen_pattern_data u_dut_a (
    .CLK(CLK), .RST_N(RST_N_a), .EN(EN_a), .MODE(MODE_a), .CONST_VAL(CONST_a),
    .READY_IN(READY_a), .DATA_OUT(DATA_A), .VALID_OUT(VALID_A), .SR_OUT(SR_A), .BUSY(BUSY_A)
  );

  gen_pattern_data #(.GAP_CYCLES(3)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N_b), .EN(EN_b), .MODE(MODE_b), .CONST_VAL(CONST_b),
    .READY_IN(READY_b), .DATA_OUT(DATA_B), .VALID_OUT(VALID_B), .SR_OUT(SR_B), .BUSY(BUSY_B)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- Frame-level model ----------------
  function automatic mst_t start_frame(input mst_t s, input int mode, input int cval);
    mst_t n = s;
    n.act  = 1'b1;
    n.row  = 0;
    n.mode = mode;
    n.cval = cval;
    n.gap  = 0;
    return n;
  endfunction

  function automatic mst_t step(input mst_t s, input bit en, input bit rdy,
                                input int mode, input int cval, input int gap_cycles);
    mst_t n = s;
    if (s.act) begin
      if (rdy) begin
        if (s.row == ROWS - 1) begin
          n.frame = s.frame + 1;
          n.act   = 1'b0;
          if (gap_cycles > 0) n.gap = gap_cycles;
          else if (en) n = start_frame(n, mode, cval);
        end else begin
          n.row = s.row + 1;
        end
      end
    end else if (s.gap > 0) begin
      n.gap = s.gap - 1;
      if (n.gap == 0 && en) n = start_frame(n, mode, cval);
    end else if (en) begin
      n = start_frame(n, mode, cval);
    end
    return n;
  endfunction

  function automatic logic [15:0] exp_data(input mst_t s);
    int w;
    logic [15:0] r;
    case (s.mode)
      0:       w = s.row % 4096;
      1:       w = s.cval % 4096;
      2:       w = 1 << (s.row % 12);
      default: w = ((s.row % 2) == 1) ? 'h555 : 'hAAA;
    endcase
    r[15:12] = 4'(s.frame % 16);
    r[11:0]  = w[11:0];
    return r;
  endfunction

  mst_t m_a = '{default: 0};
  mst_t m_b = '{default: 0};

  always @(posedge CLK or negedge RST_N_a) begin
    if (!RST_N_a) m_a <= '{default: 0};
    else          m_a <= step(m_a, EN_a, READY_a, int'(MODE_a), int'(CONST_a), 0);
  end

  always @(posedge CLK or negedge RST_N_b) begin
    if (!RST_N_b) m_b <= '{default: 0};
    else          m_b <= step(m_b, EN_b, READY_b, int'(MODE_b), int'(CONST_b), 3);
  end

  // ---------------- Per-cycle compare ----------------
  logic        pv_a = 1'b0, pr_a = 1'b1, ps_a = 1'b0;
  logic [15:0] pd_a = '0;
  logic        pv_b = 1'b0, pr_b = 1'b1, ps_b = 1'b0;
  logic [15:0] pd_b = '0;

  task automatic cmp_dut(input string tag, input mst_t m, input logic [15:0] d,
                         input logic v, input logic sr, input logic busy,
                         input logic pv, input logic pr, input logic [15:0] pd, input logic ps);
    chk({tag, "_valid"}, 32'(v), 32'(m.act));
    chk({tag, "_busy"}, 32'(busy), 32'(m.act || m.gap > 0));
    if (m.act) begin
      chk({tag, "_data"}, 32'(d), 32'(exp_data(m)));
      chk({tag, "_sr"}, 32'(sr), 32'(m.row == ROWS - 1));
      if (pv && !pr) begin
        chk({tag, "_stall_data"}, 32'(d), 32'(pd));
        chk({tag, "_stall_sr"}, 32'(sr), 32'(ps));
      end
    end
  endtask

  always @(negedge CLK) begin
    cmp_dut("A", m_a, DATA_A, VALID_A, SR_A, BUSY_A, pv_a, pr_a, pd_a, ps_a);
    cmp_dut("B", m_b, DATA_B, VALID_B, SR_B, BUSY_B, pv_b, pr_b, pd_b, ps_b);
    pv_a <= VALID_A; pr_a <= READY_a; pd_a <= DATA_A; ps_a <= SR_A;
    pv_b <= VALID_B; pr_b <= READY_b; pd_b <= DATA_B; ps_b <= SR_B;
  end

  // ---------------- Directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bit found;

    // Reset state
    tick(2);
    chk("rst_data", 32'(DATA_A), 32'h0);
    chk("rst_valid", 32'(VALID_A), 32'h0);
    chk("rst_sr", 32'(SR_A), 32'h0);
    chk("rst_busy", 32'(BUSY_A), 32'h0);
    RST_N_a = 1'b1;
    RST_N_b = 1'b1;

    // Full-throughput ramp, frame field wraps after 16 frames
    MODE_a = 2'd0; READY_a = 1'b1; EN_a = 1'b1;
    tick(1);
    chk("ramp_row0", 32'(DATA_A), 32'h0000);
    chk("ramp_row0_valid", 32'(VALID_A), 32'h1);
    chk("ramp_row0_sr", 32'(SR_A), 32'h0);
    tick(47);
    chk("ramp_row47", 32'(DATA_A), 32'h002F);
    chk("ramp_row47_sr", 32'(SR_A), 32'h1);
    tick(1);
    chk("ramp_f1_row0", 32'(DATA_A), 32'h1000);
    chk("ramp_f1_row0_sr", 32'(SR_A), 32'h0);
    tick(15 * 48);
    chk("ramp_wrap_row0", 32'(DATA_A), 32'h0000);

    // Random back-pressure
    for (int i = 0; i < 300; i++) begin
      READY_a = 1'($urandom_range(0, 1));
      tick(1);
    end
    READY_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (VALID_A && SR_A) found = 1'b1;
    end
    chk("sr_found", 32'(found), 32'h1);
    READY_a = 1'b0;
    tick(3);
    chk("sr_held", 32'(SR_A), 32'h1);
    chk("sr_held_word", 32'(DATA_A[11:0]), 32'h02F);
    READY_a = 1'b1;

    // Constant pattern with MODE switch mid-frame
    EN_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (!BUSY_A) found = 1'b1;
    end
    chk("idle_reached", 32'(found), 32'h1);
    MODE_a = 2'd1; CONST_a = 12'hABC; EN_a = 1'b1;
    tick(1);
    chk("const_row0", 32'(DATA_A[11:0]), 32'hABC);
    tick(20);
    MODE_a = 2'd3;
    tick(1);
    chk("const_row21", 32'(DATA_A[11:0]), 32'hABC);
    tick(26);
    chk("const_row47", 32'(DATA_A[11:0]), 32'hABC);
    chk("const_row47_sr", 32'(SR_A), 32'h1);
    tick(1);
    chk("check_row0", 32'(DATA_A[11:0]), 32'hAAA);
    tick(1);
    chk("check_row1", 32'(DATA_A[11:0]), 32'h555);

    // EN dropped mid-frame, then async reset mid-frame
    RST_N_a = 1'b0; EN_a = 1'b0; MODE_a = 2'd0;
    #1;
    chk("arst_valid", 32'(VALID_A), 32'h0);
    chk("arst_data", 32'(DATA_A), 32'h0);
    tick(1);
    RST_N_a = 1'b1; EN_a = 1'b1;
    tick(1);
    chk("en_f0_row0", 32'(DATA_A), 32'h0000);
    tick(10);
    EN_a = 1'b0;
    tick(37);
    chk("en_row47", 32'(DATA_A), 32'h002F);
    chk("en_row47_sr", 32'(SR_A), 32'h1);
    tick(1);
    chk("en_stop_valid", 32'(VALID_A), 32'h0);
    chk("en_stop_busy", 32'(BUSY_A), 32'h0);
    EN_a = 1'b1;
    tick(1);
    chk("en_restart_f1", 32'(DATA_A), 32'h1000);
    tick(30);
    chk("pre_rst_row30", 32'(DATA_A), 32'h101E);
    RST_N_a = 1'b0;
    #1;
    chk("midrst_data", 32'(DATA_A), 32'h0);
    chk("midrst_valid", 32'(VALID_A), 32'h0);
    chk("midrst_sr", 32'(SR_A), 32'h0);
    chk("midrst_busy", 32'(BUSY_A), 32'h0);
    #1;
    RST_N_a = 1'b1;
    tick(1);
    chk("postrst_row0", 32'(DATA_A), 32'h0000);
    chk("postrst_valid", 32'(VALID_A), 32'h1);
    EN_a = 1'b0;

    // Walking one with a 3-cycle gap on instance B
    MODE_b = 2'd2; READY_b = 1'b1; EN_b = 1'b1;
    tick(1);
    chk("walk_row0", 32'(DATA_B), 32'h0001);
    tick(11);
    chk("walk_row11", 32'(DATA_B), 32'h0800);
    tick(1);
    chk("walk_row12", 32'(DATA_B), 32'h0001);
    tick(35);
    chk("walk_row47_sr", 32'(SR_B), 32'h1);
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (VALID_B) found = 1'b1;
      else cnt++;
    end
    chk("gap_len", 32'(cnt), 32'd3);
    chk("gap_f1_row0", 32'(DATA_B), 32'h1001);
    for (int i = 0; i < 150; i++) begin
      READY_b = 1'($urandom_range(0, 1));
      tick(1);
    end
    READY_b = 1'b1;
    EN_b = 1'b0;
    tick(120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gen_pattern_data.md
Name: gen_pattern_data

Overview:
Parametrised successor to the fixed 48-row dummy-data generator. Emits frames of ROWS words, each word being {frame counter, pattern word}, with a selectable test pattern. Adds a valid/ready output handshake, run/stop control and an optional inter-frame gap. Drives the readout/DAQ path in place of the sensor for link and firmware bring-up; SR_OUT marks the last row of each frame.

Parameters:
ROWS, 48, words per frame (column count); legal range 2..65535.
WORD_W, 12, pattern word width; at least 4.
FRAME_W, 4, frame counter width; wraps modulo 2^FRAME_W.
GAP_CYCLES, 0, idle cycles with VALID_OUT=0 between frames; 0 means frames run back-to-back.

Ports:
CLK  in  1  single clock; all logic is on the rising edge.
RST_N  in  1  asynchronous, active-low reset.
EN  in  1  run request; sampled only at frame boundaries.
MODE  in  2  pattern select: 0 ramp, 1 constant, 2 walking-one, 3 checkerboard.
CONST_VAL  in  WORD_W  pattern value for MODE=1.
READY_IN  in  1  downstream ready.
DATA_OUT  out  FRAME_W+WORD_W  {frame_cnt, word}.
VALID_OUT  out  1  DATA_OUT is valid.
SR_OUT  out  1  high with the last word (row ROWS-1) of a frame.
BUSY  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (RST_N low, asynchronous): FSM=IDLE, row=0, frame_cnt=0, DATA_OUT=0, VALID_OUT=0, SR_OUT=0, BUSY=0.
- A handshake (beat) occurs when VALID_OUT & READY_IN. DATA_OUT, VALID_OUT and SR_OUT are registered and must hold stable while VALID_OUT=1 and READY_IN=0.
- The output register loads the next word when !VALID_OUT | READY_IN. This gives full throughput of one word per cycle when READY_IN is held high.
- FSM states: IDLE, RUN, GAP.
- IDLE -> RUN when EN=1. On this transition MODE and CONST_VAL are latched for the entire frame, and the word for row 0 is loaded, so VALID_OUT rises one cycle after EN is sampled.
- RUN: row counts 0..ROWS-1, advancing only on a beat.
- After the beat of row ROWS-1:
  - frame_cnt increments (wrapping);
  - if GAP_CYCLES>0, go to GAP;
  - otherwise, if EN=1, latch MODE and load row 0 of the next frame in the same cycle (no bubble);
  - otherwise go to IDLE.
- GAP: VALID_OUT=0 for exactly GAP_CYCLES cycles. Then, if EN=1, load row 0 and go to RUN; otherwise go to IDLE.
- EN deasserted mid-frame: the current frame always completes. There are no partial frames.
- Pattern word per row r (WORD_W bits):
  - ramp: r mod 2^WORD_W; restarts at 0 on each frame.
  - constant: the latched CONST_VAL.
  - walking-one: 1 << (r mod WORD_W).
  - checkerboard: 0b1010…1010 on even rows, 0b0101…0101 on odd rows.
- SR_OUT = 1 exactly when the loaded word is row ROWS-1, so it is qualified by VALID_OUT. It is held during stalls.
- The frame_cnt field of DATA_OUT is the count of frames completed before this one: 0 for the first frame after reset.
- The row counter must be $clog2(ROWS) bits wide. The ramp is computed at full width and then truncated to WORD_W.
- A MODE change mid-frame has no effect until the next frame start.
- Asserting RST_N low mid-frame aborts immediately. On release, the block restarts at frame 0, row 0.

Decomposition:
- Package gen_pattern_pkg:
  - MODE encodings (MODE_RAMP=0, MODE_CONST=1, MODE_WALK=2, MODE_CHECK=3);
  - FSM state enum;
  - helper function for the checkerboard constant of a given width.
- One sub-module, gen_pattern_word: combinational pattern generator taking mode, row and const and returning the word. The top module holds the FSM, counters and output register.

Test Plan:
- Defaults; EN=1, READY_IN=1, MODE=0 -> continuous VALID_OUT; frame 0 words 0x000..0x02F; SR_OUT only on word 0x02F. Next word is 0x1000; after 16 frames the frame field wraps to 0.
- READY_IN toggled pseudo-randomly -> DATA_OUT stable during every stall. Scoreboard sequence is identical to the full-throughput run, and SR_OUT is held while stalled on row 47.
- GAP_CYCLES=3, MODE=2 -> rows 0..11 give 0x001..0x800, then rows 12..23 repeat the sequence. Exactly 3 cycles of VALID_OUT=0 between frames.
- MODE=1, CONST_VAL=0xABC; MODE switched to 3 at row 20 -> 0xABC for all 48 rows; the next frame alternates 0xAAA/0x555.
- EN dropped at row 10 -> frame completes through row 47. Then BUSY=0 and VALID_OUT=0. Re-asserting EN starts a frame with field 1 (frame_cnt=1).
- RST_N pulsed low asynchronously at row 30 -> outputs are 0 immediately. After release with EN=1, the next frame starts at row 0 with frame field 0.
